// File: rtl/jesd_sync_ctrl.sv
// JESD204B receive-side SYNC~ controller: SYSREF capture, LMFC tracking,
// per-lane code-group sync, LMFC-aligned link bring-up and error resync.
module jesd_sync_ctrl #(
  parameter int LANES       = 4,
  parameter int LMFC_CYCLES = 8,
  parameter int K_MIN       = 4,
  parameter int ERR_THRESH  = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             sysref_i,
  input  logic             en_i,
  input  logic [LANES-1:0] kchar_i,
  input  logic [LANES-1:0] lane_err_i,
  output logic             sync_o,
  output logic             lmfc_edge_o,
  output logic             link_up_o,
  output logic             sysref_seen_o,
  output logic [1:0]       state_o
);

  localparam int CW = (LMFC_CYCLES > 1) ? $clog2(LMFC_CYCLES) : 1;
  localparam int KW = $clog2(K_MIN + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam logic [CW-1:0] LMFC_LAST = CW'(LMFC_CYCLES - 1);
  localparam logic [KW-1:0] K_FULL    = KW'(K_MIN);
  localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_THRESH - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CGS       = 2'd1,
    WAIT_LMFC = 2'd2,
    DATA      = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic            sysref_meta_reg, sysref_sync_reg, sysref_dly_reg, sysref_pulse_reg;
  logic            sysref_seen_reg;
  logic [CW-1:0]   lmfc_cnt_reg;
  logic [EW-1:0]   err_cnt_reg;
  logic            sync_reg;
  logic [LANES-1:0] k_full;
  logic            any_err;
  logic            err_hit;

  // Pulse is registered, so it lands one cycle after the second flop sees 1.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sysref_meta_reg  <= 1'b0;
      sysref_sync_reg  <= 1'b0;
      sysref_dly_reg   <= 1'b0;
      sysref_pulse_reg <= 1'b0;
      sysref_seen_reg  <= 1'b0;
    end else begin
      sysref_meta_reg  <= sysref_i;
      sysref_sync_reg  <= sysref_meta_reg;
      sysref_dly_reg   <= sysref_sync_reg;
      sysref_pulse_reg <= sysref_sync_reg & ~sysref_dly_reg;
      if (sysref_pulse_reg) sysref_seen_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      lmfc_cnt_reg <= '0;
    else if (sysref_pulse_reg || lmfc_cnt_reg == LMFC_LAST)
      lmfc_cnt_reg <= '0;
    else
      lmfc_cnt_reg <= lmfc_cnt_reg + 1'b1;
  end

  assign lmfc_edge_o = (lmfc_cnt_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [KW-1:0] k_cnt_reg;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
          k_cnt_reg <= '0;
        else if (state_reg != CGS || !kchar_i[gi] || lane_err_i[gi])
          k_cnt_reg <= '0;
        else if (k_cnt_reg != K_FULL)
          k_cnt_reg <= k_cnt_reg + 1'b1;
      end
      assign k_full[gi] = (k_cnt_reg == K_FULL);
    end
  endgenerate

  // An LMFC boundary clears the error window, so it also blocks a threshold hit.
  assign any_err = |lane_err_i;
  assign err_hit = (state_reg == DATA) && any_err && !lmfc_edge_o && (err_cnt_reg == ERR_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      err_cnt_reg <= '0;
    else if (state_reg != DATA || lmfc_edge_o || err_hit)
      err_cnt_reg <= '0;
    else if (any_err)
      err_cnt_reg <= err_cnt_reg + 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    if (!en_i) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:      if (sysref_seen_reg) state_next = CGS;
        CGS:       if (&k_full)         state_next = WAIT_LMFC;
        WAIT_LMFC: if (lmfc_edge_o)     state_next = DATA;
        DATA:      if (err_hit)         state_next = CGS;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      sync_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sync_reg  <= (state_next == DATA);
    end
  end

  assign sync_o        = sync_reg;
  assign link_up_o     = (state_reg == DATA);
  assign sysref_seen_o = sysref_seen_reg;
  assign state_o       = state_reg;

endmodule
